spectrum_packet_buffer: RTL
===========================

# spectrum_packet_buffer

Store-and-forward packet buffer directly downstream of the sensor acquisition stage, feeding the DMA/AXI-Stream sink. It accepts the acquisition stream (header 0xAAAAAAAA, timestamp, payload, footer 0x55555555, and a final 0xBBBBBBBB word with tlast), checks the framing of each packet and stores it in a block-RAM FIFO. Only complete, well-formed packets are released downstream. The upstream source never honours backpressure, so malformed or overflowing packets are dropped whole, by rolling back the write pointer.

## Interface
Parameters:
- ADDR_W, 11: FIFO address width; DEPTH = 2**ADDR_W words (2048)
- RAW_WORDS, 512: payload words per packet in raw mode
- PROC_WORDS, 3: payload words per packet in processed mode

Ports:
- master_clock  in  1  clock (40 MHz)
- resetn  in  1  synchronous, active-low reset
- raw_mode  in  1  payload length select, sampled on the header beat: 1 = RAW_WORDS, 0 = PROC_WORDS
- s_tdata  in  32  input stream data
- s_tvalid  in  1  input beat valid
- s_tlast  in  1  input last flag
- s_tready  out  1  tied to 1; the source cannot stall
- m_tdata  out  32  output data
- m_tvalid  out  1  output valid
- m_tlast  out  1  output last; stored per word as FIFO bit 32
- m_tready  in  1  output ready
- pkt_ok_count  out  16  packets committed, wraps
- pkt_drop_count  out  16  packets rolled back, wraps
- hdr_err_count  out  16  beats discarded while waiting for a header, wraps
- overflow  out  1  sticky; set when any packet is dropped for lack of space
- fill_level  out  ADDR_W+1  wr_ptr − rd_ptr

## Operation
- Memory: DEPTH × 33 bits (data plus tlast), simple dual-port, synchronous read.
- Pointers: wr_ptr, commit_ptr and rd_ptr, each ADDR_W+1 bits with natural wrap. Full when wr_ptr − rd_ptr == DEPTH.
- A write means: store the beat at wr_ptr, then wr_ptr+1. If the FIFO is full, the beat is not stored and the packet's ovf flag is set.
- Parser FSM; only beats with s_tvalid=1 act:
  - S_HDR:
    - Beat = 0xAAAAAAAA: write it, latch the length from raw_mode, → S_TS.
    - Beat = 0xBBBBBBBB with s_tlast=1: write it and commit it immediately (commit_ptr ← new wr_ptr); stay in S_HDR. Not counted as a packet.
    - Any other beat: discard it, hdr_err_count+1.
  - S_TS: write the timestamp, clear cnt, → S_PAY.
  - S_PAY: write the beat, cnt+1; when cnt reaches length−1, → S_FTR.
  - S_FTR:
    - Beat = 0x55555555 and ovf=0: write it, commit, pkt_ok_count+1.
    - Otherwise: wr_ptr ← commit_ptr, pkt_drop_count+1; if ovf, set overflow.
    - Either way, → S_HDR.
- Framing error inside a packet: if a header value or any s_tlast=1 beat arrives in S_TS/S_PAY, roll back and count a drop, then process the beat as if in S_HDR, in the same cycle.
- Output side: a show-ahead register stage reads memory while rd_ptr ≠ commit_ptr. The transfer handshake is m_tvalid & m_tready. m_tvalid never drops without a transfer, and m_tdata is stable while stalled.
- Counters: saturate nowhere; wrap at 16 bits.

## Timing
- Reset values: all pointers 0, state S_HDR, m_tvalid 0, m_tdata 0, m_tlast 0, all counters 0, overflow 0, fill_level 0, s_tready 1.
- Reset asserted mid-operation: all stored data, committed or not, is flushed on the next edge.
- Commit takes effect on the clock edge that accepts the footer.
- With the output empty, m_tvalid rises exactly 2 cycles after that edge, carrying the header word.
- Sustained throughput is 1 word/cycle in and out, simultaneously.
- Commit and read in the same cycle: the read compares against the pre-commit commit_ptr; the new words become visible on the next cycle.
- Rollback and read in the same cycle are independent, because reads never pass commit_ptr.
- fill_level updates one cycle after a pointer change.
- Pointer wrap-around is seamless; full and empty are decided only by the pointer-difference MSB logic.

## Test plan
- Processed packet: raw_mode=0; send AAAAAAAA, 0x00000010, 3 data words, 55555555 with m_tready=1 → the same 6 words appear on the output, m_tvalid rises 2 cycles after the footer beat, pkt_ok_count=1.
- Raw packet followed by the tlast word: raw_mode=1; send a 515-word packet, then BBBBBBBB with tlast → 516 words output, m_tlast=1 only on BBBBBBBB.
- Bad footer: footer replaced by 0x12345678 → nothing output, pkt_drop_count=1, fill_level returns to its prior value. A following good packet passes intact.
- Overflow: m_tready=0, send 4 raw packets (2060 words) → first 3 committed (1545 words), 4th dropped, overflow=1. Then m_tready=1 → exactly 1545 words drain.
- Garbage and early tlast: 5 junk beats before a header → hdr_err_count=5. BBBBBBBB with tlast during payload → drop+1, and BBBBBBBB is output alone.
- Reset mid-packet: assert resetn=0 for 1 cycle during payload → fill_level=0, m_tvalid=0, counters 0. The next packet passes normally.

Source files
------------

// File: rtl/spectrum_packet_buffer.sv
// Store-and-forward packet FIFO: framing check on input, only committed packets are read out.
// Latency: m_tvalid 2 cycles after commit edge; input never stalls (bad/overflowing packets rolled back), output obeys m_tready.
module spectrum_packet_buffer #(
    parameter int ADDR_W     = 11,
    parameter int RAW_WORDS  = 512,
    parameter int PROC_WORDS = 3
) (
    input  logic              master_clock,
    input  logic              resetn,
    input  logic              raw_mode,
    input  logic [31:0]       s_tdata,
    input  logic              s_tvalid,
    input  logic              s_tlast,
    output logic              s_tready,
    output logic [31:0]       m_tdata,
    output logic              m_tvalid,
    output logic              m_tlast,
    input  logic              m_tready,
    output logic [15:0]       pkt_ok_count,
    output logic [15:0]       pkt_drop_count,
    output logic [15:0]       hdr_err_count,
    output logic              overflow,
    output logic [ADDR_W:0]   fill_level
);
    localparam int              DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_DIFF = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] PTR_ONE   = 1;
    localparam logic [31:0]     HDR_WORD  = 32'hAAAA_AAAA;
    localparam logic [31:0]     FTR_WORD  = 32'h5555_5555;
    localparam logic [31:0]     END_WORD  = 32'hBBBB_BBBB;

    typedef enum logic [1:0] {S_HDR, S_TS, S_PAY, S_FTR} state_t;

    state_t          state, eff_state;
    logic [ADDR_W:0] wr_ptr, commit_ptr, rd_ptr, base_ptr, wr_ptr_n;
    logic [15:0]     cnt, len;
    logic            ovf;
    logic            is_hdr, is_end, is_ftr, frame_err, full;
    logic            want_write, store, ftr_commit, ftr_drop, commit, ovf_set;
    logic [32:0]     mem [DEPTH];
    logic [32:0]     mem_q;
    logic            s1_vld, s2_load, rd_en;

    assign s_tready = 1'b1;

    always_comb begin
        is_hdr     = (s_tdata == HDR_WORD);
        is_end     = s_tlast && (s_tdata == END_WORD);
        is_ftr     = (s_tdata == FTR_WORD);
        // A header or tlast mid-packet kills the packet and the beat is re-parsed as a fresh start.
        frame_err  = s_tvalid && ((state == S_TS) || (state == S_PAY)) && (is_hdr || s_tlast);
        eff_state  = frame_err ? S_HDR : state;
        base_ptr   = frame_err ? commit_ptr : wr_ptr;
        full       = ((base_ptr - rd_ptr) == FULL_DIFF);
        want_write = 1'b0;
        if (s_tvalid) begin
            case (eff_state)
                S_HDR:       want_write = is_hdr || is_end;
                S_TS, S_PAY: want_write = 1'b1;
                default:     want_write = is_ftr && !ovf;
            endcase
        end
        store      = want_write && !full;
        wr_ptr_n   = store ? base_ptr + PTR_ONE : base_ptr;
        ftr_commit = s_tvalid && (state == S_FTR) && is_ftr && !ovf && !full;
        ftr_drop   = s_tvalid && (state == S_FTR) && !ftr_commit;
        if (ftr_drop) wr_ptr_n = commit_ptr;
        commit     = ftr_commit || (s_tvalid && (eff_state == S_HDR) && is_end);
        ovf_set    = (ftr_drop && (ovf || (is_ftr && full))) || (frame_err && ovf);
    end

    // Reads stop at commit_ptr, so rollback never races the output side.
    assign s2_load = !m_tvalid || m_tready;
    assign rd_en   = (rd_ptr != commit_ptr) && (!s1_vld || s2_load);

    always_ff @(posedge master_clock) begin
        if (store) mem[base_ptr[ADDR_W-1:0]] <= {s_tlast, s_tdata};
        if (rd_en) mem_q <= mem[rd_ptr[ADDR_W-1:0]];
    end

    always_ff @(posedge master_clock) begin
        if (!resetn) begin
            state          <= S_HDR;
            wr_ptr         <= '0;
            commit_ptr     <= '0;
            rd_ptr         <= '0;
            cnt            <= '0;
            len            <= '0;
            ovf            <= 1'b0;
            overflow       <= 1'b0;
            pkt_ok_count   <= '0;
            pkt_drop_count <= '0;
            hdr_err_count  <= '0;
            fill_level     <= '0;
            s1_vld         <= 1'b0;
            m_tvalid       <= 1'b0;
            m_tdata        <= '0;
            m_tlast        <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_n;
            if (commit)                 commit_ptr     <= wr_ptr_n;
            if (frame_err || ftr_drop)  pkt_drop_count <= pkt_drop_count + 16'd1;
            if (ftr_commit)             pkt_ok_count   <= pkt_ok_count + 16'd1;
            if (ovf_set)                overflow       <= 1'b1;
            if (s_tvalid && (eff_state == S_HDR) && !is_hdr && !is_end)
                hdr_err_count <= hdr_err_count + 16'd1;
            if (s_tvalid) begin
                case (eff_state)
                    S_HDR: begin
                        if (is_hdr) begin
                            state <= S_TS;
                            len   <= raw_mode ? 16'(RAW_WORDS) : 16'(PROC_WORDS);
                            ovf   <= full;
                        end else begin
                            state <= S_HDR;
                        end
                    end
                    S_TS: begin
                        cnt   <= '0;
                        ovf   <= ovf || full;
                        state <= S_PAY;
                    end
                    S_PAY: begin
                        cnt <= cnt + 16'd1;
                        ovf <= ovf || full;
                        if (cnt == len - 16'd1) state <= S_FTR;
                    end
                    default: state <= S_HDR;
                endcase
            end
            fill_level <= wr_ptr - rd_ptr;
            rd_ptr     <= rd_ptr + (ADDR_W+1)'(rd_en);
            if (rd_en)        s1_vld <= 1'b1;
            else if (s2_load) s1_vld <= 1'b0;
            if (s2_load) begin
                m_tvalid <= s1_vld;
                if (s1_vld) {m_tlast, m_tdata} <= mem_q;
            end
        end
    end
endmodule
